keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- 4x4 matrix keypad scanner feeding the IO segment of the memory/peripheral controller.
- Drives the `rows` strobes and samples `cols`, then debounces whole-matrix snapshots.
- Each debounced single-key press is encoded as a 4-bit key code and pushed into a small FIFO.
- The controller reads the FIFO head as a 32-bit IO word and pops it with a one-cycle read strobe.

Parameters:
- SCAN_DIV, 1000: clock cycles each row is driven (dwell); minimum 2.
- DEBOUNCE_SCANS, 4: consecutive identical full-matrix snapshots required before a snapshot is accepted as stable; minimum 1.
- FIFO_DEPTH, 4: key-code FIFO entries; power of two, maximum 4.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- cols  input  4  column sense lines; active-high, 1 = key closed on the currently driven row.
- rows  output  4  row drive; one-hot, active-high.
- rdEn  input  1  one-cycle pop strobe from the IO segment read; also clears overflow.
- keyData  output  32  IO read word (layout under Behaviour).
- keyValid  output  1  FIFO non-empty; equals keyData[4].

Behaviour:
- Reset: one clock, synchronous, active-high. Applies on any cycle, including mid-scan or mid-debounce.
  - `rows`=4'b0001, row index=0, dwell counter=0.
  - Snapshot and debounce counters cleared; state=IDLE.
  - FIFO empty, overflow=0, keyData=32'h0, keyValid=0.
- Scan:
  - Dwell counter counts 0..SCAN_DIV-1.
  - `cols` is sampled at count SCAN_DIV-1 into snapshot bits [row*4+3:row*4].
  - Row then advances, wrapping 3->0; `rows` rotates left, 4'b1000 -> 4'b0001.
  - One full scan = 4*SCAN_DIV cycles.
- Snapshot commit:
  - Occurs the cycle after row 3 is sampled.
  - If the new snapshot equals the previous one, the match counter increments, saturating; otherwise the counter resets to 1.
  - When the counter reaches DEBOUNCE_SCANS, the snapshot becomes the stable value.
- Key code: bit index row*4+col, range 0..15.
- FSM, evaluated on stable-value update:
  - IDLE: stable has exactly one bit set -> push its code, go to PRESSED. Zero or multiple bits -> stay, no push.
  - PRESSED: stable==0 -> RELEASE. Any non-zero value (including a different key or extra keys) -> stay, no push.
  - RELEASE: the next stable update returns the FSM to IDLE and is evaluated as IDLE in that same cycle.
- Push timing: the push lands in the FIFO the cycle after the stable update.
- FIFO:
  - Synchronous; head is registered.
  - rdEn on empty is ignored (no underflow, count stays 0).
  - Push on full with no simultaneous pop -> code dropped, overflow set (sticky).
  - Push and pop in the same cycle when full -> both accepted, count unchanged, no overflow.
  - Push and pop in the same cycle when empty -> push only.
  - Pointers wrap modulo FIFO_DEPTH.
- rdEn clears overflow in the same cycle it pops; a drop occurring in that same cycle wins (overflow stays 1).
- keyData layout:
  - [3:0] head code.
  - [4] valid.
  - [7:5] 0.
  - [10:8] count, 0..FIFO_DEPTH.
  - [30:11] 0.
  - [31] overflow.
  - [3:0] reads 0 when empty.
- keyData updates the cycle after any push, pop or reset.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - Adds parameter REPEAT_SCANS, default 64.
  - In PRESSED with the stable value unchanged, the held code is re-pushed once every REPEAT_SCANS completed snapshot commits.
  - The repeat counter clears on entry to PRESSED and on reset.
  - Repeat pushes obey the same full/overflow rules as normal pushes.
- Undefined: exactly one push per press; no repeat logic synthesised.

Test Plan:
- Bench setup: SCAN_DIV=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4; one scan = 16 cycles.
- Reset: assert rst 1 cycle, cols=0.
  -> rows=0001, keyData=0, keyValid=0.
  -> rows reads 0010 after 4 cycles and wraps to 0001 after 16.
- Single press: close row 2 col 1 for 5 scans, then release.
  -> keyValid=1, keyData=32'h0000_0119 after the 2nd matching commit.
  -> rdEn pulse gives keyData=0; release produces no further push.
- Bounce: toggle the row 0 col 0 contact every scan for 4 scans, then hold.
  -> no push while toggling; exactly one push of code 0 after 2 steady scans.
- Multi-key: hold keys 5 and 6 together, release, then press key 15.
  -> nothing pushed for 5+6; one push of code 15.
- Overflow: 5 separate presses of code 3 with no reads.
  -> count=4, keyData=32'h8000_0413.
  -> rdEn gives count=3 with bit31=0.
- Simultaneous and reset edge cases:
  - With the FIFO full, 6th press completes on the same cycle as rdEn -> count stays 4, overflow=0.
  - rst asserted mid-dwell with 2 entries queued -> FIFO empty, rows=0001 next cycle.

Source files
------------

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scanner with debounce, key-code FIFO and 32-bit IO read word.
// Optional key auto-repeat is compiled in when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
`ifdef KEYPAD_REPEAT_EN
  , parameter int REPEAT_SCANS = 64
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  cols,
  output logic [3:0]  rows,
  input  logic        rdEn,
  output logic [31:0] keyData,
  output logic        keyValid
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [MW-1:0] MATCH_TGT = MW'(DEBOUNCE_SCANS);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [2:0] DEPTH_C = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PRESSED, RELEASE} state_t;

  logic [DW-1:0] dwell;
  logic [1:0]    row_idx;
  logic [15:0]   snap, prev_snap, stable;
  logic          commit_req, stable_upd;
  logic [MW-1:0] match_cnt, match_nxt;
  state_t        state, state_nxt;
  logic          push;
  logic [3:0]    push_code, key_code;
  logic          one_hot;
  logic [3:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [2:0]    count;
  logic          overflow, pop, full, do_push, drop;

  // Row strobe and column sampling; a full snapshot is committed one cycle after row 3.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell      <= '0;
      row_idx    <= 2'd0;
      rows       <= 4'b0001;
      snap       <= '0;
      commit_req <= 1'b0;
    end else begin
      commit_req <= 1'b0;
      if (dwell == DIV_LAST) begin
        dwell                      <= '0;
        snap[{row_idx, 2'b00} +: 4] <= cols;
        row_idx                    <= row_idx + 2'd1;
        rows                       <= {rows[2:0], rows[3]};
        if (row_idx == 2'd3) commit_req <= 1'b1;
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  always_comb begin
    match_nxt = MW'(1);
    if (snap == prev_snap)
      match_nxt = (match_cnt == MATCH_TGT) ? match_cnt : match_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_snap  <= '0;
      match_cnt  <= '0;
      stable     <= '0;
      stable_upd <= 1'b0;
    end else begin
      stable_upd <= 1'b0;
      if (commit_req) begin
        prev_snap <= snap;
        match_cnt <= match_nxt;
        if (match_nxt == MATCH_TGT) begin
          stable     <= snap;
          stable_upd <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    key_code = 4'd0;
    for (int i = 0; i < 16; i++)
      if (stable[i]) key_code = 4'(i);
    one_hot = (stable != 16'd0) && ((stable & (stable - 16'd1)) == 16'd0);
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] rep_cnt;
  logic [3:0]    held_code;
  logic          held_same, rep_hit;

  assign held_same = (stable == (16'd1 << held_code));
  assign rep_hit   = (state == PRESSED) && stable_upd && held_same &&
                     (rep_cnt == RW'(REPEAT_SCANS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt   <= '0;
      held_code <= 4'd0;
    end else if (state != PRESSED && state_nxt == PRESSED) begin
      rep_cnt   <= '0;
      held_code <= key_code;
    end else if (state == PRESSED && stable_upd) begin
      rep_cnt <= (held_same && !rep_hit) ? rep_cnt + 1'b1 : '0;
    end
  end
`endif

  // RELEASE shares the IDLE evaluation so a new press on the very next update is not lost.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_code = key_code;
    if (stable_upd) begin
      case (state)
        IDLE, RELEASE: begin
          state_nxt = IDLE;
          if (one_hot) begin
            push      = 1'b1;
            state_nxt = PRESSED;
          end
        end
        PRESSED: begin
          if (stable == 16'd0) state_nxt = RELEASE;
`ifdef KEYPAD_REPEAT_EN
          else if (rep_hit) begin
            push      = 1'b1;
            push_code = held_code;
          end
`endif
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // When full, wr_ptr == rd_ptr, so a simultaneous push overwrites exactly the popped head.
  assign pop     = rdEn && (count != 3'd0);
  assign full    = (count == DEPTH_C);
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !pop)      count <= count + 3'd1;
      else if (pop && !do_push) count <= count - 3'd1;
      if (drop)      overflow <= 1'b1;
      else if (rdEn) overflow <= 1'b0;
    end
  end

  assign keyValid = (count != 3'd0);
  assign keyData  = {overflow, 20'd0, count, 3'd0, keyValid,
                     keyValid ? fifo_mem[rd_ptr] : 4'd0};

endmodule
